// File: rtl/vector_merge_sequencer.sv
// vector_merge_sequencer
// Walks a merge instruction across its register group, one member per cycle.
// For each member it issues a register-file read and a merge-unit issue. A
// LATENCY-deep tracker delays the destination address so that wb_valid and
// wb_addr line up with the merge unit's vd output.
// The decoded control word is opaque here: it is captured and forwarded as-is,
// so its type is a parameter supplied by the integrating level.
module vector_merge_sequencer #(
    parameter int  LATENCY            = 2,
    parameter int  REG_ADDR_W         = 5,
    parameter type execution_vector_t = logic [11:0]
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  execution_vector_t     req_execution_vector,
    input  logic [REG_ADDR_W-1:0] req_vd_addr,
    input  logic [REG_ADDR_W-1:0] req_vs1_addr,
    input  logic [REG_ADDR_W-1:0] req_vs2_addr,
    input  logic [3:0]            req_group_count,
    output logic                  rf_read_valid,
    output logic [REG_ADDR_W-1:0] rf_vs1_addr,
    output logic [REG_ADDR_W-1:0] rf_vs2_addr,
    output logic [2:0]            rf_group_index,
    output logic                  mu_issue,
    output execution_vector_t     mu_execution_vector,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [2:0]              k_reg;
    logic [3:0]              count_reg;
    logic [REG_ADDR_W-1:0]   vd_base_reg;
    logic                    issue_reg;
    logic [REG_ADDR_W-1:0]   rf_vs1_reg;
    logic [REG_ADDR_W-1:0]   rf_vs2_reg;
    logic                    err_reg;
    execution_vector_t       ev_reg;

    // Write-back tracker: entry 0 is loaded by the issue cycle, the last
    // entry is the head that lines up with the merge unit's vd.
    logic [LATENCY-1:0]      pipe_valid;
    logic [LATENCY-1:0]      pipe_last;
    logic [REG_ADDR_W-1:0]   pipe_addr [LATENCY];

    logic                    count_ok;
    logic [REG_ADDR_W-1:0]   align_mask;
    logic                    req_legal;
    logic                    issue_last;
    logic [REG_ADDR_W-1:0]   issue_wb_addr;
    logic                    head_done;

    // Request legality: power-of-two group size and every base aligned to it,
    // which also guarantees base+k never wraps past the top register.
    always_comb begin
        count_ok   = (req_group_count == 4'd1) || (req_group_count == 4'd2) ||
                     (req_group_count == 4'd4) || (req_group_count == 4'd8);
        align_mask = REG_ADDR_W'(req_group_count - 4'd1);
        req_legal  = count_ok &&
                     ((req_vd_addr  & align_mask) == '0) &&
                     ((req_vs1_addr & align_mask) == '0) &&
                     ((req_vs2_addr & align_mask) == '0);
    end

    // Per-issue bookkeeping: is this the final member, and where does it land.
    always_comb begin
        issue_last    = (k_reg == 3'(count_reg - 4'd1));
        issue_wb_addr = vd_base_reg + REG_ADDR_W'(k_reg);
        head_done     = pipe_valid[LATENCY-1] & pipe_last[LATENCY-1];
    end

    // Control FSM with registered issue outputs; addresses step by one per
    // issue and simply hold once the group is finished.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            k_reg       <= '0;
            count_reg   <= '0;
            vd_base_reg <= '0;
            issue_reg   <= 1'b0;
            rf_vs1_reg  <= '0;
            rf_vs2_reg  <= '0;
            err_reg     <= 1'b0;
            ev_reg      <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        ev_reg      <= req_execution_vector;
                        count_reg   <= req_group_count;
                        vd_base_reg <= req_vd_addr;
                        k_reg       <= '0;
                        if (req_legal) begin
                            state_reg  <= S_ISSUE;
                            issue_reg  <= 1'b1;
                            rf_vs1_reg <= req_vs1_addr;
                            rf_vs2_reg <= req_vs2_addr;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue_last) begin
                        state_reg <= S_DRAIN;
                        issue_reg <= 1'b0;
                    end else begin
                        k_reg      <= k_reg + 3'd1;
                        rf_vs1_reg <= rf_vs1_reg + REG_ADDR_W'(1);
                        rf_vs2_reg <= rf_vs2_reg + REG_ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (head_done) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    issue_reg <= 1'b0;
                end
            endcase
        end
    end

    // Write-back tracker shift: one entry per cycle, bubbles carry valid=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue_reg;
            pipe_last[0]  <= issue_reg & issue_last;
            pipe_addr[0]  <= issue_wb_addr;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
        end
    end

    assign req_ready           = (state_reg == S_IDLE);
    assign busy                = (state_reg != S_IDLE);
    assign rf_read_valid       = issue_reg;
    assign mu_issue            = issue_reg;
    assign rf_vs1_addr         = rf_vs1_reg;
    assign rf_vs2_addr         = rf_vs2_reg;
    assign rf_group_index      = k_reg;
    assign mu_execution_vector = ev_reg;
    assign wb_valid            = pipe_valid[LATENCY-1];
    assign wb_addr             = pipe_addr[LATENCY-1];
    assign done                = head_done;
    assign err                 = err_reg;

endmodule
